// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings and data-phase state constants for the custom M0 slaves.
package ahb_pkg;
    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;
    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;
    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR1 = 2'd2;
    localparam logic [1:0] ST_ERR2 = 2'd3;
endpackage

// File: rtl/ahb_byte_lane_decode.sv
// ahb_byte_lane_decode: maps HSIZE and HADDR[1:0] to a byte-lane mask plus a size/alignment error.
module ahb_byte_lane_decode
    import ahb_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] addr_lo,
    output logic [3:0] lane_mask,
    output logic       lane_err
);
    always_comb begin
        lane_mask = hsize == HSIZE_BYTE ? 4'b0001 << addr_lo
                  : hsize == HSIZE_HALF ? 4'b0011 << {addr_lo[1], 1'b0}
                  : 4'b1111;
        lane_err  = hsize > HSIZE_WORD
                  || (hsize == HSIZE_HALF && addr_lo[0])
                  || (hsize == HSIZE_WORD && addr_lo != 2'b00);
    end
endmodule

// File: rtl/ahb_param_regbank.sv
// ahb_param_regbank: AHB-Lite slave with NUM_REGS byte-writable 32-bit registers exported on regs_o,
// optional OKAY wait states and a two-cycle ERROR response for illegal accesses.
module ahb_param_regbank
    import ahb_pkg::*;
#(
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] RESET_VALUE = 32'h0
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [31:0]            HADDR,
    input  logic [31:0]            HWDATA,
    input  logic [2:0]             HSIZE,
    input  logic [1:0]             HTRANS,
    input  logic                   HWRITE,
    input  logic                   HREADY,
    input  logic                   HSEL,
    output logic [31:0]            HRDATA,
    output logic                   HREADYOUT,
    output logic                   HRESP,
    output logic [NUM_REGS*32-1:0] regs_o
);
    localparam int IDX_W = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;

    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
        $error("ahb_param_regbank: WAIT_STATES must be 0..15");
    end
    if (NUM_REGS < 1 || NUM_REGS > 256) begin : g_bad_regs
        $error("ahb_param_regbank: NUM_REGS must be 1..256");
    end

    logic [NUM_REGS-1:0][31:0] regs;
    logic [3:0]                lane_mask;
    logic                      lane_err;
    logic [IDX_W-1:0]          a_idx;
    logic                      a_err;
    logic                      cap;
    logic [1:0]                state;
    logic [3:0]                cnt;
    logic                      dp_valid;
    logic                      dp_write;
    logic                      dp_err;
    logic [IDX_W-1:0]          dp_idx;
    logic [3:0]                dp_mask;
    logic                      stall;
    logic                      complete;
    logic [31:0]               rd_word;
    logic                      unused;

    ahb_byte_lane_decode u_lane (
        .hsize     (HSIZE),
        .addr_lo   (HADDR[1:0]),
        .lane_mask (lane_mask),
        .lane_err  (lane_err)
    );

    // Upper address bits alias onto the decoded window.
    assign unused    = ^{HADDR[31:IDX_W+2], HTRANS[0]};
    assign cap       = HSEL && HREADY && HTRANS[1];
    assign a_idx     = HADDR[IDX_W+1:2];
    assign a_err     = lane_err || ({1'b0, a_idx} >= (IDX_W+1)'(NUM_REGS));
    assign stall     = state == ST_ERR1 || (state == ST_WAIT && cnt != 4'd0);
    assign complete  = dp_valid && !dp_err && !stall;
    assign HREADYOUT = !stall;
    assign HRESP     = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA    = (dp_valid && !dp_write && !dp_err) ? rd_word : 32'h0;
    assign regs_o    = regs;

    always_comb begin
        rd_word = 32'h0;
        for (int i = 0; i < NUM_REGS; i++)
            if (dp_idx == IDX_W'(i)) rd_word = regs[i];
    end

    // A new address phase is only taken once the current data phase stops stalling.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_err   <= 1'b0;
            dp_idx   <= '0;
            dp_mask  <= 4'd0;
        end else if (state == ST_ERR1) begin
            state <= ST_ERR2;
        end else if (stall) begin
            cnt <= cnt - 4'd1;
        end else if (cap) begin
            dp_valid <= 1'b1;
            dp_write <= HWRITE;
            dp_idx   <= a_idx;
            dp_mask  <= lane_mask;
            dp_err   <= a_err;
            state    <= a_err ? ST_ERR1 : WAIT_STATES != 0 ? ST_WAIT : ST_IDLE;
            cnt      <= a_err ? 4'd0 : 4'(WAIT_STATES);
        end else begin
            state    <= ST_IDLE;
            dp_valid <= 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            regs <= {NUM_REGS{RESET_VALUE}};
        else if (complete && dp_write)
            for (int i = 0; i < NUM_REGS; i++)
                for (int b = 0; b < 4; b++)
                    if (dp_idx == IDX_W'(i) && dp_mask[b]) regs[i][8*b +: 8] <= HWDATA[8*b +: 8];
    end
endmodule

// File: tb/tb_ahb_param_regbank.sv
// tb_ahb_param_regbank: directed and random AHB-Lite traffic on two regbank configurations,
// checked cycle by cycle against a transaction-level register model.
module tb_ahb_param_regbank;
    import ahb_pkg::*;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    localparam logic [31:0] RV1 = 32'hA5A5_0F0F;

    int          nr [2] = '{8, 6};
    int          ws [2] = '{0, 2};
    logic [31:0] rv [2] = '{32'h0, RV1};

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] haddr [2];
    logic [31:0] hwdata [2];
    logic [2:0]  hsize [2];
    logic [1:0]  htrans [2];
    logic        hwrite [2];
    logic        hsel [2];
    logic [31:0] rd0, rd1;
    logic        rdy0, rdy1, resp0, resp1;
    logic [255:0] regs0;
    logic [191:0] regs1;
    logic [31:0] mem [2][8];
    xfer_t       xq [$];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    ahb_param_regbank #(.NUM_REGS(8), .WAIT_STATES(0), .RESET_VALUE(32'h0)) u_dut0 (
        .HCLK(clk), .HRESETn(rstn), .HADDR(haddr[0]), .HWDATA(hwdata[0]), .HSIZE(hsize[0]),
        .HTRANS(htrans[0]), .HWRITE(hwrite[0]), .HREADY(rdy0), .HSEL(hsel[0]),
        .HRDATA(rd0), .HREADYOUT(rdy0), .HRESP(resp0), .regs_o(regs0));

    ahb_param_regbank #(.NUM_REGS(6), .WAIT_STATES(2), .RESET_VALUE(RV1)) u_dut1 (
        .HCLK(clk), .HRESETn(rstn), .HADDR(haddr[1]), .HWDATA(hwdata[1]), .HSIZE(hsize[1]),
        .HTRANS(htrans[1]), .HWRITE(hwrite[1]), .HREADY(rdy1), .HSEL(hsel[1]),
        .HRDATA(rd1), .HREADYOUT(rdy1), .HRESP(resp1), .regs_o(regs1));

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic rdy_of(input int k);
        return k == 0 ? rdy0 : rdy1;
    endfunction
    function automatic logic resp_of(input int k);
        return k == 0 ? resp0 : resp1;
    endfunction
    function automatic logic [31:0] rd_of(input int k);
        return k == 0 ? rd0 : rd1;
    endfunction
    function automatic logic [255:0] regs_of(input int k);
        return k == 0 ? regs0 : {64'h0, regs1};
    endfunction

    // Model: word index is the address modulo the 8-word decode window.
    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 2) % 8);
    endfunction
    function automatic logic err_of(input int k, input xfer_t x);
        return idx_of(x.addr) >= nr[k] || x.size > 3'd2 || (x.addr % (1 << x.size)) != 0;
    endfunction
    function automatic logic [255:0] model_regs(input int k);
        logic [255:0] r = '0;
        for (int i = 0; i < nr[k]; i++) r[32*i +: 32] = mem[k][i];
        return r;
    endfunction

    task automatic apply(input int k, input xfer_t x);
        int off = int'(x.addr % 4);
        for (int b = off; b < off + (1 << x.size); b++)
            mem[k][idx_of(x.addr)][8*b +: 8] = x.wdata[8*b +: 8];
    endtask

    task automatic reset_model();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 8; i++) mem[k][i] = rv[k];
    endtask

    function automatic xfer_t mk(input logic sel, input logic [1:0] trans, input logic wr,
                                 input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
        xfer_t x;
        x.sel = sel; x.trans = trans; x.wr = wr; x.addr = addr; x.size = size; x.wdata = wdata;
        return x;
    endfunction

    task automatic push(input logic sel, input logic [1:0] trans, input logic wr,
                        input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
        xq.push_back(mk(sel, trans, wr, addr, size, wdata));
    endtask

    task automatic push_rand();
        int sz = $urandom_range(0, 7) == 0 ? $urandom_range(3, 7) : $urandom_range(0, 2);
        int lo = $urandom_range(0, 31);
        logic act = $urandom_range(0, 4) != 0;
        if (sz <= 2 && $urandom_range(0, 3) != 0) lo = lo & ~((1 << sz) - 1);
        push($urandom_range(0, 7) != 0, {act, 1'($urandom)}, 1'($urandom),
             ($urandom << 5) | 32'(lo), 3'(sz), $urandom);
    endtask

    task automatic drive(input int k, input xfer_t c);
        hsel[k]   = c.sel;
        htrans[k] = c.trans;
        hwrite[k] = c.wr;
        haddr[k]  = c.addr;
        hsize[k]  = c.size;
    endtask

    task automatic chk_reset(input int k);
        chk("rst_regs", regs_of(k), model_regs(k));
        chk("rst_hreadyout", rdy_of(k), 1'b1);
        chk("rst_hresp", resp_of(k), 1'b0);
        chk("rst_hrdata", rd_of(k), 32'h0);
    endtask

    // Plays the queued transfers as a pipelined master and checks every cycle.
    task automatic run(input int k);
        xfer_t p, c;
        bit pv = 0;
        logic perr = 1'b0, erdy, eresp;
        logic [31:0] edata;
        int cyc = 0, guard = 0;
        while (xq.size() > 0 || pv) begin
            @(negedge clk);
            chk("regs", regs_of(k), model_regs(k));
            cyc++;
            guard++;
            if (guard > 64) begin
                chk("stall_guard", 32'(guard), 32'd0);
                xq.delete();
                break;
            end
            erdy  = pv ? (perr ? cyc == 2 : cyc == ws[k] + 1) : 1'b1;
            eresp = pv && perr;
            edata = (pv && !perr && !p.wr) ? mem[k][idx_of(p.addr)] : 32'h0;
            chk("hreadyout", rdy_of(k), erdy);
            chk("hresp", resp_of(k), eresp);
            chk("hrdata", rd_of(k), edata);
            if (rdy_of(k)) begin
                if (pv && !perr && p.wr) apply(k, p);
                pv = 0;
                c = mk(1'b0, HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
                if (xq.size() > 0) c = xq.pop_front();
                drive(k, c);
                if (c.sel && c.trans[1]) begin
                    p = c;
                    pv = 1;
                    cyc = 0;
                    guard = 0;
                    perr = err_of(k, c);
                end
                @(posedge clk);
                #1;
                if (pv && cyc == 0) hwdata[k] = p.wdata;
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            drive(k, mk(1'b0, HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0));
            hwdata[k] = 32'h0;
        end
        reset_model();
        repeat (2) @(negedge clk);
        chk_reset(0);
        chk_reset(1);
        rstn = 1'b1;

        push(1, HTRANS_NONSEQ, 1, 32'h08, HSIZE_WORD, 32'hDEADBEEF);
        push(1, HTRANS_NONSEQ, 0, 32'h08, HSIZE_WORD, 32'h0);
        run(0);
        chk("reg2_word", regs0[95:64], 32'hDEADBEEF);

        push(1, HTRANS_NONSEQ, 1, 32'h04, HSIZE_WORD, 32'h11223344);
        push(1, HTRANS_NONSEQ, 1, 32'h07, HSIZE_BYTE, 32'hAA00_0000);
        run(0);
        chk("reg1_byte", regs0[63:32], 32'hAA223344);
        push(1, HTRANS_NONSEQ, 1, 32'h04, HSIZE_HALF, 32'h0000_5566);
        run(0);
        chk("reg1_half", regs0[63:32], 32'hAA225566);

        // 0x..20 aliases onto reg0 because only HADDR[4:0] is decoded.
        push(1, HTRANS_NONSEQ, 1, 32'h02, HSIZE_WORD, 32'hFFFF_FFFF);
        push(1, HTRANS_NONSEQ, 1, 32'hFFFF_FF20, HSIZE_WORD, 32'h0BAD_F00D);
        run(0);
        chk("reg0_alias", regs0[31:0], 32'h0BAD_F00D);
        chk("reg1_kept", regs0[63:32], 32'hAA225566);

        push(1, HTRANS_NONSEQ, 1, 32'h10, HSIZE_WORD, 32'h1111_2222);
        push(1, HTRANS_SEQ, 0, 32'h10, HSIZE_WORD, 32'h0);
        push(1, HTRANS_IDLE, 1, 32'h14, HSIZE_WORD, 32'h3333_4444);
        push(1, HTRANS_BUSY, 1, 32'h14, HSIZE_WORD, 32'h5555_6666);
        push(0, HTRANS_NONSEQ, 1, 32'h14, HSIZE_WORD, 32'h7777_8888);
        push(1, HTRANS_SEQ, 0, 32'h14, HSIZE_WORD, 32'h0);
        run(0);
        chk("reg5_untouched", regs0[191:160], 32'h0);

        push(1, HTRANS_NONSEQ, 0, 32'h0C, HSIZE_WORD, 32'h0);
        push(1, HTRANS_NONSEQ, 1, 32'h18, HSIZE_WORD, 32'h1234_5678);
        push(1, HTRANS_NONSEQ, 1, 32'h1F, HSIZE_BYTE, 32'hFF00_0000);
        push(1, HTRANS_NONSEQ, 1, 32'h01, HSIZE_HALF, 32'hFFFF_FFFF);
        push(1, HTRANS_NONSEQ, 1, 32'h00, 3'd3, 32'hFFFF_FFFF);
        push(1, HTRANS_NONSEQ, 0, 32'h18, HSIZE_WORD, 32'h0);
        push(1, HTRANS_NONSEQ, 1, 32'h14, HSIZE_WORD, 32'hCAFE_0001);
        run(1);
        chk("reg0_err_kept", regs1[31:0], RV1);
        chk("reg5_ws_write", regs1[191:160], 32'hCAFE_0001);

        @(negedge clk);
        drive(1, mk(1'b1, HTRANS_NONSEQ, 1'b1, 32'h0C, HSIZE_WORD, 32'h0));
        @(posedge clk);
        #1;
        hwdata[1] = 32'h1357_9BDF;
        drive(1, mk(1'b0, HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0));
        @(negedge clk);
        chk("mid_wait_low", rdy1, 1'b0);
        #2 rstn = 1'b0;
        #1;
        reset_model();
        chk_reset(0);
        chk_reset(1);
        @(negedge clk);
        rstn = 1'b1;
        push(1, HTRANS_NONSEQ, 0, 32'h0C, HSIZE_WORD, 32'h0);
        run(1);
        chk("reg3_dropped", regs1[127:96], RV1);

        for (int k = 0; k < 2; k++) begin
            repeat (250) push_rand();
            run(k);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
